fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller that fetches 16-bit instructions from 8-bit-wide memory and loads them into the instruction register.
- Each fetch is two byte reads: low byte first, then high byte.
- Drives the instruction register's Write, LH and byte inputs, and owns the program counter.
- Presents a completed instruction to the decoder with a level handshake (InstrValid / ExecDone) and supports branch redirect.

Parameters:
ADDR_W, 16, width of program counter and memory address.
RESET_PC, 0, PC value loaded on reset.
TIMEOUT_CYCLES, 15, max consecutive MemReady-low cycles tolerated in a request state; 0 disables the timeout.

Ports:
Clock  in  1  rising-edge clock.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  run enable; sampled only in IDLE and on ExecDone.
MemReady  in  1  memory byte valid on MemData this cycle.
MemData  in  8  byte returned by memory.
ExecDone  in  1  execute stage finished the current instruction.
PCLoad  in  1  branch redirect; honoured only together with ExecDone in WAIT_EXEC.
PCIn  in  ADDR_W  branch target.
MemReq  out  1  memory read request.
MemAddr  out  ADDR_W  read address (equals PC).
IRWrite  out  1  to instruction register Write.
IRLH  out  1  to instruction register LH (0 = low byte, 1 = high byte).
IRData  out  8  to instruction register byte input.
InstrValid  out  1  instruction register holds a complete instruction.
PC  out  ADDR_W  program counter.
Busy  out  1  state is neither IDLE nor FAULT.
Fault  out  1  memory timeout; sticky until reset.

Behaviour:
- Reset low, asynchronous and immediate, from any state:
  - state = IDLE, PC = RESET_PC, byte register = 0, wait counter = 0.
  - All other outputs = 0.
- Output timing: all outputs are decoded from registered state, PC and byte register only. No combinational input-to-output path.
- States and transitions:
  - IDLE: all strobes 0. Start=1 -> REQ_LO.
  - REQ_LO: MemReq=1, MemAddr=PC. On an edge with MemReady=1: byte_reg <= MemData, PC <= PC+1, -> WR_LO.
  - WR_LO: IRWrite=1, IRLH=0, IRData=byte_reg. Lasts exactly 1 cycle, then -> REQ_HI.
  - REQ_HI: same as REQ_LO, but -> WR_HI.
  - WR_HI: IRWrite=1, IRLH=1, IRData=byte_reg. Lasts 1 cycle, then -> WAIT_EXEC.
  - WAIT_EXEC: InstrValid=1, held until ExecDone=1. On that edge:
    - If PCLoad=1, PC <= PCIn; otherwise PC is unchanged.
    - Start=1 -> REQ_LO; otherwise -> IDLE.
  - FAULT: Fault=1, MemReq=0. The only exit is reset.
- Timeout:
  - The wait counter clears on entering REQ_LO or REQ_HI and increments on each REQ cycle with MemReady=0.
  - When the counter reaches TIMEOUT_CYCLES with MemReady still 0 -> FAULT.
  - If MemReady=1 in that same cycle, the accept wins.
  - TIMEOUT_CYCLES=0 disables the timeout: the block waits forever.
- Latency:
  - Zero-wait memory: InstrValid rises 4 edges after the edge that samples Start=1.
  - The IR high byte is written on that same edge.
  - Back-to-back instruction interval is 5 cycles minimum.
- Boundary conditions:
  - PC wraps modulo 2^ADDR_W. A low byte fetched at the maximum address is followed by the high byte at address 0.
  - MemReady outside REQ states is ignored.
  - PCLoad without ExecDone, or outside WAIT_EXEC, is ignored.
  - ExecDone outside WAIT_EXEC is ignored.
  - Start deasserted mid-fetch: the fetch completes and InstrValid is still asserted. Start is re-checked only at ExecDone.
  - The IR is never written outside WR_LO and WR_HI, so it holds its contents while the sequencer is idle.

Test Plan:
- Reset, then Start=1; memory returns 0x34 then 0x12 with zero wait -> MemAddr 0x0000 then 0x0001; IR = 0x1234; InstrValid high at edge 4; PC = 0x0002.
- Memory asserts MemReady after 3 wait cycles per byte -> IRWrite pulses are exactly 1 cycle each; IR correct; no Fault.
- MemReady held low with TIMEOUT_CYCLES=15 -> Fault=1 after 15 wait cycles; MemReq=0; Busy=0; only reset clears Fault.
- In WAIT_EXEC, ExecDone=1 with PCLoad=1 and PCIn=0x0100 -> next MemAddr = 0x0100. PCLoad pulsed without ExecDone -> PC unchanged.
- RESET_PC=0xFFFF -> low byte read at 0xFFFF, high byte at 0x0000; PC = 0x0001 at InstrValid.
- Reset asserted during REQ_HI -> outputs zero and PC=RESET_PC immediately without a clock edge; Start=1 after release restarts the fetch from the low byte.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads low then high byte from 8-bit memory into the IR, owns the PC.
// Latency: InstrValid rises 4 edges after Start is sampled (zero-wait memory); minimum 5 cycles per instruction.
// Backpressure: stalls in request states while MemReady=0 (optional timeout to FAULT); holds InstrValid until ExecDone.
// Ports: Clock/Reset (async active-low); memory side MemReq/MemAddr/MemReady/MemData;
//        IR side IRWrite/IRLH/IRData; decoder side InstrValid/ExecDone/PCLoad/PCIn; status PC/Busy/Fault.
module fetch_sequencer #(
    parameter int                 ADDR_W         = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
    parameter int                 TIMEOUT_CYCLES = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              MemReady,
    input  logic [7:0]        MemData,
    input  logic              ExecDone,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              IRWrite,
    output logic              IRLH,
    output logic [7:0]        IRData,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LO,
        S_WR_LO,
        S_REQ_HI,
        S_WR_HI,
        S_WAIT_EXEC,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    // Outputs are flops loaded from the next-state decode, so nothing
    // combinational reaches a port from an input.
    logic       mem_req_q, mem_req_d;
    logic       ir_write_q, ir_write_d;
    logic       ir_lh_q, ir_lh_d;
    logic [7:0] ir_data_q, ir_data_d;
    logic       instr_valid_q, instr_valid_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        byte_d  = byte_q;
        wait_d  = wait_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_REQ_LO;
                    wait_d  = '0;
                end
            end
            S_REQ_LO, S_REQ_HI: begin
                // An accept in the same cycle the limit is reached wins over the timeout.
                if (MemReady) begin
                    byte_d  = MemData;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = (state_q == S_REQ_LO) ? S_WR_LO : S_WR_HI;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (wait_q == TMO_LIMIT) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
            end
            S_WR_LO: begin
                state_d = S_REQ_HI;
                wait_d  = '0;
            end
            S_WR_HI: begin
                state_d = S_WAIT_EXEC;
            end
            S_WAIT_EXEC: begin
                if (ExecDone) begin
                    if (PCLoad) begin
                        pc_d = PCIn;
                    end
                    if (Start) begin
                        state_d = S_REQ_LO;
                        wait_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d     = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
        ir_write_d    = (state_d == S_WR_LO) || (state_d == S_WR_HI);
        ir_lh_d       = (state_d == S_WR_HI);
        ir_data_d     = ir_write_d ? byte_d : 8'h00;
        instr_valid_d = (state_d == S_WAIT_EXEC);
        busy_d        = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            byte_q        <= 8'h00;
            wait_q        <= '0;
            mem_req_q     <= 1'b0;
            ir_write_q    <= 1'b0;
            ir_lh_q       <= 1'b0;
            ir_data_q     <= 8'h00;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            byte_q        <= byte_d;
            wait_q        <= wait_d;
            mem_req_q     <= mem_req_d;
            ir_write_q    <= ir_write_d;
            ir_lh_q       <= ir_lh_d;
            ir_data_q     <= ir_data_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    assign MemReq     = mem_req_q;
    assign MemAddr    = pc_q;
    assign IRWrite    = ir_write_q;
    assign IRLH       = ir_lh_q;
    assign IRData     = ir_data_q;
    assign InstrValid = instr_valid_q;
    assign PC         = pc_q;
    assign Busy       = busy_q;
    assign Fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle table, hand-written corner sequences,
// and a randomized run checked by a transaction-level scoreboard.
// Second instance uses RESET_PC=0xFFFF with the timeout disabled.
module tb_fetch_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        MemReady;
    logic [7:0]  MemData;
    logic        ExecDone;
    logic        PCLoad;
    logic [15:0] PCIn;

    logic        MemReq, IRWrite, IRLH, InstrValid, Busy, Fault;
    logic [15:0] MemAddr, PC;
    logic [7:0]  IRData;

    logic        w_MemReq, w_IRWrite, w_IRLH, w_InstrValid, w_Busy, w_Fault;
    logic [15:0] w_MemAddr, w_PC;
    logic [7:0]  w_IRData;

    fetch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MemReady(MemReady), .MemData(MemData),
        .ExecDone(ExecDone), .PCLoad(PCLoad), .PCIn(PCIn),
        .MemReq(MemReq), .MemAddr(MemAddr), .IRWrite(IRWrite), .IRLH(IRLH), .IRData(IRData),
        .InstrValid(InstrValid), .PC(PC), .Busy(Busy), .Fault(Fault)
    );

    fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF), .TIMEOUT_CYCLES(0)) dut_w (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MemReady(MemReady), .MemData(MemData),
        .ExecDone(ExecDone), .PCLoad(PCLoad), .PCIn(PCIn),
        .MemReq(w_MemReq), .MemAddr(w_MemAddr), .IRWrite(w_IRWrite), .IRLH(w_IRLH), .IRData(w_IRData),
        .InstrValid(w_InstrValid), .PC(w_PC), .Busy(w_Busy), .Fault(w_Fault)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Model of the downstream instruction register fed by the IR strobes.
    logic [7:0] ir_lo, ir_hi;
    always @(posedge Clock) begin
        if (IRWrite) begin
            if (IRLH) ir_hi <= IRData;
            else      ir_lo <= IRData;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Leaves the caller at a falling edge with reset just released and all inputs low.
    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0; MemReady = 1'b0; MemData = 8'h00;
        ExecDone = 1'b0; PCLoad = 1'b0; PCIn = 16'h0000;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    typedef struct {
        logic        start, ready;
        logic [7:0]  data;
        logic        exec, pcl;
        logic [15:0] pcin;
        logic        req, irw, irlh;
        logic [7:0]  ird;
        logic        iv, busy;
        logic [15:0] pc, wpc;
    } vec_t;

    vec_t tbl [9];

    // Scoreboard state for the randomized run
    logic [15:0] exp_pc, lo_a, hi_a, last_a;
    int          k_bytes, wcnt;
    logic        iv_m, iv_first, wr_next, wr_half, new_wr, new_half, req_chk, req_val;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0; MemReady = 1'b0; MemData = 8'h00;
        ExecDone = 1'b0; PCLoad = 1'b0; PCIn = 16'h0000;

        // ---------------- asynchronous reset values ----------------
        #2 Reset = 1'b0;
        #1;
        chk("rst_memreq", MemReq, 1'b0);
        chk("rst_irwrite", IRWrite, 1'b0);
        chk("rst_instrvalid", InstrValid, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_fault", Fault, 1'b0);
        chk("rst_pc", PC, 16'h0000);
        chk("rst_irdata", IRData, 8'h00);
        chk("rst_w_pc", w_PC, 16'hFFFF);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // ---------------- cycle table: zero-wait fetch, PCLoad, redirect ----------------
        //          start ready data  exec pcl pcin      req irw lh ird   iv busy pc        wpc
        tbl[0] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'hFFFF};
        tbl[1] = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
        tbl[2] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h34, 1'b0, 1'b1, 16'h0001, 16'h0000};
        tbl[3] = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0001, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 16'h0002, 16'h0001};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0002, 16'h0001};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0002, 16'h0001};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0100, 16'h0100};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0100, 16'h0100};

        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl%0d_memreq", i), MemReq, tbl[i].req);
            chk($sformatf("tbl%0d_irwrite", i), IRWrite, tbl[i].irw);
            if (tbl[i].irw) begin
                chk($sformatf("tbl%0d_irlh", i), IRLH, tbl[i].irlh);
                chk($sformatf("tbl%0d_irdata", i), IRData, tbl[i].ird);
            end
            chk($sformatf("tbl%0d_instrvalid", i), InstrValid, tbl[i].iv);
            chk($sformatf("tbl%0d_busy", i), Busy, tbl[i].busy);
            chk($sformatf("tbl%0d_pc", i), PC, tbl[i].pc);
            chk($sformatf("tbl%0d_memaddr", i), MemAddr, tbl[i].pc);
            chk($sformatf("tbl%0d_fault", i), Fault, 1'b0);
            chk($sformatf("tbl%0d_wrap_pc", i), w_PC, tbl[i].wpc);
            chk($sformatf("tbl%0d_wrap_memaddr", i), w_MemAddr, tbl[i].wpc);
            Start    = tbl[i].start;
            MemReady = tbl[i].ready;
            MemData  = tbl[i].data;
            ExecDone = tbl[i].exec;
            PCLoad   = tbl[i].pcl;
            PCIn     = tbl[i].pcin;
            @(negedge Clock);
        end
        chk("tbl_ir_word", {ir_hi, ir_lo}, 16'h1234);

        // ---------------- reset asserted during REQ_HI ----------------
        do_reset();
        Start = 1'b1; MemReady = 1'b1; MemData = 8'h11;
        @(negedge Clock);                       // REQ_LO
        Start = 1'b0;
        @(negedge Clock);                       // WR_LO
        @(negedge Clock);                       // REQ_HI
        chk("midrst_pre_memreq", MemReq, 1'b1);
        chk("midrst_pre_addr", MemAddr, 16'h0001);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_memreq", MemReq, 1'b0);
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_irwrite", IRWrite, 1'b0);
        chk("midrst_pc", PC, 16'h0000);
        chk("midrst_w_pc", w_PC, 16'hFFFF);
        @(negedge Clock);
        Reset = 1'b1; Start = 1'b1; MemReady = 1'b0;
        @(negedge Clock);
        chk("restart_memreq", MemReq, 1'b1);
        chk("restart_addr", MemAddr, 16'h0000);
        MemReady = 1'b1; MemData = 8'h99;
        @(negedge Clock);
        chk("restart_irwrite", IRWrite, 1'b1);
        chk("restart_irlh", IRLH, 1'b0);
        chk("restart_irdata", IRData, 8'h99);

        // ---------------- timeout: 15 low cycles tolerated, 16th faults ----------------
        do_reset();
        Start = 1'b1; MemReady = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clock);
            chk($sformatf("tmo_wait%0d_fault", k), Fault, 1'b0);
            chk($sformatf("tmo_wait%0d_memreq", k), MemReq, 1'b1);
        end
        @(negedge Clock);
        chk("tmo_fault", Fault, 1'b1);
        chk("tmo_memreq", MemReq, 1'b0);
        chk("tmo_busy", Busy, 1'b0);
        chk("tmo_disabled_fault", w_Fault, 1'b0);
        chk("tmo_disabled_memreq", w_MemReq, 1'b1);
        MemReady = 1'b1; ExecDone = 1'b1;
        repeat (5) @(negedge Clock);
        chk("tmo_sticky_fault", Fault, 1'b1);
        chk("tmo_sticky_memreq", MemReq, 1'b0);
        do_reset();
        chk("tmo_cleared_fault", Fault, 1'b0);

        // ---------------- accept on the limit cycle wins ----------------
        Start = 1'b1; MemReady = 1'b0;
        repeat (16) @(negedge Clock);
        MemReady = 1'b1; MemData = 8'h5C;
        @(negedge Clock);
        chk("edge_accept_fault", Fault, 1'b0);
        chk("edge_accept_irwrite", IRWrite, 1'b1);
        chk("edge_accept_irdata", IRData, 8'h5C);
        chk("edge_accept_pc", PC, 16'h0001);

        // ---------------- scoreboarded run: fixed 3-wait memory, then random ----------------
        do_reset();
        exp_pc = 16'h0000; k_bytes = 0; wcnt = 0;
        iv_m = 1'b0; iv_first = 1'b0; wr_next = 1'b0; wr_half = 1'b0;
        req_chk = 1'b0; req_val = 1'b0;
        lo_a = '0; hi_a = '0; last_a = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            chk("rnd_instrvalid", InstrValid, iv_m);
            chk("rnd_irwrite", IRWrite, wr_next);
            chk("rnd_fault", Fault, 1'b0);
            if (wr_next) begin
                chk("rnd_irlh", IRLH, wr_half);
                chk("rnd_irdata", IRData, mem_byte(last_a));
            end
            if (MemReq) chk("rnd_memaddr", MemAddr, exp_pc);
            if (iv_m) chk("rnd_no_req_while_valid", MemReq, 1'b0);
            if (req_chk) chk("rnd_memreq", MemReq, req_val);
            if (iv_first) begin
                chk("rnd_ir_word", {ir_hi, ir_lo}, {mem_byte(hi_a), mem_byte(lo_a)});
                chk("rnd_pc_at_valid", PC, exp_pc);
            end

            if (cyc < 100) MemReady = (wcnt == 3);
            else           MemReady = ($urandom_range(0, 3) != 0);
            if (MemReq) wcnt = MemReady ? 0 : wcnt + 1;
            MemData  = mem_byte(MemAddr);
            Start    = ($urandom_range(0, 7) != 0);
            ExecDone = ($urandom_range(0, 2) == 0);
            PCLoad   = $urandom_range(0, 1) != 0;
            PCIn     = 16'($urandom);

            // Predict what the coming edge produces.
            req_chk  = 1'b0;
            new_wr   = 1'b0;
            new_half = 1'b0;
            if (wr_next && !wr_half) begin
                req_chk = 1'b1;
                req_val = 1'b1;
            end
            if (MemReq && MemReady) begin
                last_a = exp_pc;
                if (k_bytes == 0) lo_a = exp_pc;
                else              hi_a = exp_pc;
                new_wr   = 1'b1;
                new_half = (k_bytes != 0);
                exp_pc   = exp_pc + 16'd1;
                k_bytes++;
            end
            iv_first = wr_next && wr_half;
            if (iv_first) iv_m = 1'b1;
            if (iv_m && !iv_first && ExecDone) begin
                iv_m = 1'b0;
                if (PCLoad) exp_pc = PCIn;
                k_bytes = 0;
                req_chk = 1'b1;
                req_val = Start;
            end
            wr_next = new_wr;
            wr_half = new_half;
            @(negedge Clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
